// File: rtl/dds_pkg.sv
// Shared constants, waveform encoding and the quarter-wave sine table builder
// for the dual-tone DDS generator.
package dds_pkg;
    localparam int PHASE_W   = 48;
    localparam int DATA_W    = 10;
    localparam int AMP_W     = 9;
    localparam int ROM_DEPTH = 256;
    localparam int ROM_AW    = 8;
    localparam int MAG_W     = 9;
    localparam int IDX_W     = 10;
    localparam int DDS_LAT   = 4;
    localparam int AMP_UNITY = 256;
    localparam int GAIN_SH   = 8;
    localparam int PROD_W    = DATA_W + AMP_W + 1;
    localparam int MIX_W     = DATA_W + 1;

    typedef enum logic {
        WAVE_SINE = 1'b0,
        WAVE_TRI  = 1'b1
    } wave_e;

    typedef logic [ROM_DEPTH-1:0][MAG_W-1:0] rom_t;

    // pi/2 in Q30; entries are round(511*sin(pi/2*(k+0.5)/256)) via a Taylor series
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    function automatic logic [MAG_W-1:0] sine_entry(input int k);
        longint x, x2, term, sum;
        x    = (HALF_PI_Q30 * longint'(2 * k + 1)) / 64'sd512;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        sum = (sum * 64'sd511 + (64'sd1 <<< 29)) >>> 30;
        return sum[MAG_W-1:0];
    endfunction

    function automatic rom_t build_sine_rom();
        rom_t rom;
        for (int k = 0; k < ROM_DEPTH; k++) begin
            rom[k] = sine_entry(k);
        end
        return rom;
    endfunction
endpackage

// File: rtl/dds_quarter_sine_rom.sv
// 256 x 9 quarter-wave sine magnitude table with two registered read ports,
// one per DDS channel.
module dds_quarter_sine_rom
    import dds_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ROM_AW-1:0] addr_a_i,
    input  logic [ROM_AW-1:0] addr_b_i,
    output logic [MAG_W-1:0]  data_a_o,
    output logic [MAG_W-1:0]  data_b_o
);
    localparam rom_t ROM = build_sine_rom();

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_a_o <= '0;
            data_b_o <= '0;
        end else begin
            data_a_o <= ROM[addr_a_i];
            data_b_o <= ROM[addr_b_i];
        end
    end
endmodule

// File: rtl/dual_tone_dds_gen.sv
// Two 48-bit DDS channels (sine or triangle, per-channel gain) summed into one
// 10-bit signed sample stream through a 4-stage pipeline.
module dual_tone_dds_gen
    import dds_pkg::*;
(
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     en,
    input  logic                     phase_clr,
    input  logic                     fre_load,
    input  logic [PHASE_W-1:0]       Fre1,
    input  logic [PHASE_W-1:0]       Fre2,
    input  logic [1:0]               wave_sel,
    input  logic [AMP_W-1:0]         amp1,
    input  logic [AMP_W-1:0]         amp2,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     sync1,
    output logic                     sync2
);
    // Each cycle with en high (and no phase_clr) launches exactly one sample;
    // data_valid is that launch delayed DDS_LAT cycles, there is no back-pressure.
    logic                     launch;
    logic                     v1_q, v2_q, v3_q;
    logic [PHASE_W-1:0]       fre_w    [2];
    logic [AMP_W-1:0]         amp_w    [2];
    logic [ROM_AW-1:0]        rom_addr [2];
    logic [MAG_W-1:0]         rom_data [2];
    logic signed [DATA_W-1:0] scaled_w [2];
    logic [1:0]               sync3_w;
    logic signed [MIX_W-1:0]  mix_w;

    assign launch   = en & ~phase_clr;
    assign fre_w[0] = Fre1;
    assign fre_w[1] = Fre2;
    assign amp_w[0] = amp1;
    assign amp_w[1] = amp2;

    dds_quarter_sine_rom u_rom (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .addr_a_i (rom_addr[0]),
        .addr_b_i (rom_addr[1]),
        .data_a_o (rom_data[0]),
        .data_b_o (rom_data[1])
    );

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [PHASE_W-1:0]       acc_q, shadow_q;
        logic [PHASE_W:0]         sum_d;
        logic                     pend_q;
        logic [IDX_W-1:0]         s1_ph_q;
        logic                     s1_sync_q, s2_sync_q, s3_sync_q;
        wave_e                    s1_wave_q, s2_wave_q;
        logic [AMP_W-1:0]         amp_c, s1_amp_q, s2_amp_q;
        logic [ROM_AW-1:0]        m_w;
        logic                     s2_neg_q;
        logic [MAG_W-1:0]         s2_tri_q, mag_w;
        logic signed [DATA_W-1:0] sval_w, s3_scaled_q;
        logic signed [PROD_W-1:0] prod_w;

        assign sum_d  = {1'b0, acc_q} + {1'b0, shadow_q};
        assign amp_c  = (amp_w[c] > AMP_W'(AMP_UNITY)) ? AMP_W'(AMP_UNITY) : amp_w[c];
        // Odd quadrants walk the quarter table backwards: 255-i is ~i on 8 bits
        assign m_w    = s1_ph_q[8] ? ~s1_ph_q[7:0] : s1_ph_q[7:0];
        assign mag_w  = (s2_wave_q == WAVE_TRI) ? s2_tri_q : rom_data[c];
        assign sval_w = s2_neg_q ? -$signed({1'b0, mag_w}) : $signed({1'b0, mag_w});
        assign prod_w = PROD_W'(sval_w) * $signed({{(PROD_W-AMP_W){1'b0}}, s2_amp_q});
        assign rom_addr[c] = m_w;
        assign scaled_w[c] = s3_scaled_q;
        assign sync3_w[c]  = s3_sync_q;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                acc_q       <= '0;
                shadow_q    <= '0;
                pend_q      <= 1'b1;  // the first sample after reset opens a period
                s1_ph_q     <= '0;
                s1_sync_q   <= 1'b0;
                s1_wave_q   <= WAVE_SINE;
                s1_amp_q    <= '0;
                s2_neg_q    <= 1'b0;
                s2_tri_q    <= '0;
                s2_wave_q   <= WAVE_SINE;
                s2_amp_q    <= '0;
                s2_sync_q   <= 1'b0;
                s3_scaled_q <= '0;
                s3_sync_q   <= 1'b0;
            end else begin
                if (phase_clr) begin
                    acc_q  <= '0;
                    pend_q <= 1'b1;
                end else if (en) begin
                    acc_q  <= sum_d[PHASE_W-1:0];
                    pend_q <= sum_d[PHASE_W];
                end
                if (fre_load) begin
                    shadow_q <= fre_w[c];
                end
                s1_ph_q     <= acc_q[PHASE_W-1 -: IDX_W];
                s1_sync_q   <= launch & pend_q;
                s1_wave_q   <= wave_e'(wave_sel[c]);
                s1_amp_q    <= amp_c;
                s2_neg_q    <= s1_ph_q[9];
                s2_tri_q    <= {m_w, 1'b1};
                s2_wave_q   <= s1_wave_q;
                s2_amp_q    <= s1_amp_q;
                s2_sync_q   <= s1_sync_q;
                s3_scaled_q <= DATA_W'(prod_w >>> GAIN_SH);
                s3_sync_q   <= s2_sync_q;
            end
        end
    end

    assign mix_w = MIX_W'(scaled_w[0]) + MIX_W'(scaled_w[1]);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
        end else begin
            v1_q       <= launch;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            data_valid <= v3_q;
            sync1      <= v3_q & sync3_w[0];
            sync2      <= v3_q & sync3_w[1];
            if (v3_q) begin
                data_out <= mix_w[DATA_W:1];
            end
        end
    end
endmodule

// File: tb/tb_dual_tone_dds_gen.sv
// Bench for dual_tone_dds_gen: table vectors from the tone recipes, hand-built
// handshake/clear/load/reset sequences, and random traffic against a reference model.
module tb_dual_tone_dds_gen;
    localparam logic [47:0] F_Q = 48'h4000_0000_0000;
    localparam logic [47:0] F_H = 48'h8000_0000_0000;
    localparam real PI = 3.14159265358979323846;

    logic        sys_clk = 1'b0;
    logic        sys_rst, en, phase_clr, fre_load;
    logic [47:0] Fre1, Fre2;
    logic [1:0]  wave_sel;
    logic [8:0]  amp1, amp2;
    logic signed [9:0] data_out;
    logic        data_valid, sync1, sync2;

    int total = 0;
    int bad = 0;
    logic [12:0] exp_q[$];
    logic [47:0] m_acc [2];
    logic [47:0] m_sh  [2];
    logic        m_pend[2];

    typedef struct {
        logic [47:0]     f1, f2;
        logic [1:0]      ws;
        logic [8:0]      a1, a2;
        logic [3:0][9:0] d;
        bit              r1, r2;
    } vec_t;
    vec_t vecs [7];

    dual_tone_dds_gen dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .phase_clr(phase_clr),
        .fre_load(fre_load), .Fre1(Fre1), .Fre2(Fre2), .wave_sel(wave_sel),
        .amp1(amp1), .amp2(amp2), .data_out(data_out), .data_valid(data_valid),
        .sync1(sync1), .sync2(sync2)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int chan_val(logic [47:0] ph, logic w, logic [8:0] amp);
        int p, q, i, m, mag, s, ac;
        p = int'(ph[47:38]);
        q = p / 256;
        i = p % 256;
        m = (q % 2 == 1) ? 255 - i : i;
        if (w) mag = 2 * m + 1;
        else   mag = $rtoi(511.0 * $sin(PI / 2.0 * (real'(m) + 0.5) / 256.0) + 0.5);
        s  = (q >= 2) ? -mag : mag;
        ac = (amp > 9'd256) ? 256 : int'(amp);
        return (s * ac) >>> 8;
    endfunction

    function automatic logic [9:0] mix_val(logic [47:0] p1, logic [47:0] p2,
                                           logic [1:0] ws, logic [8:0] a1, logic [8:0] a2);
        int v;
        v = (chan_val(p1, ws[0], a1) + chan_val(p2, ws[1], a2)) >>> 1;
        return 10'(v);
    endfunction

    function automatic logic [3:0][9:0] pack4(int p0, int p1, int p2, int p3);
        logic [3:0][9:0] r;
        r[0] = 10'(p0); r[1] = 10'(p1); r[2] = 10'(p2); r[3] = 10'(p3);
        return r;
    endfunction

    // One clock: advance the model with the current inputs, then compare outputs after the edge.
    task automatic step();
        logic [12:0] rec;
        logic [48:0] t;
        logic        rst_now;
        rec     = '0;
        rst_now = sys_rst;
        if (rst_now) begin
            for (int c = 0; c < 2; c++) begin
                m_acc[c] = '0; m_sh[c] = '0; m_pend[c] = 1'b1;
            end
            exp_q.delete();
            for (int k = 0; k < 3; k++) exp_q.push_back('0);
        end else begin
            if (phase_clr) begin
                for (int c = 0; c < 2; c++) begin m_acc[c] = '0; m_pend[c] = 1'b1; end
            end else if (en) begin
                rec = {1'b1, m_pend[0], m_pend[1],
                       mix_val(m_acc[0], m_acc[1], wave_sel, amp1, amp2)};
                for (int c = 0; c < 2; c++) begin
                    t = {1'b0, m_acc[c]} + {1'b0, m_sh[c]};
                    m_acc[c]  = t[47:0];
                    m_pend[c] = t[48];
                end
            end
            if (fre_load) begin m_sh[0] = Fre1; m_sh[1] = Fre2; end
            exp_q.push_back(rec);
            rec = exp_q.pop_front();
        end
        @(posedge sys_clk);
        #1;
        check("model_valid", int'(data_valid), int'(rec[12]));
        check("model_sync1", int'(sync1), int'(rec[11]));
        check("model_sync2", int'(sync2), int'(rec[10]));
        if (rec[12] || rst_now) check("model_data", int'(data_out), int'($signed(rec[9:0])));
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; en = 1'b0; phase_clr = 1'b0; fre_load = 1'b0;
        step();
        sys_rst = 1'b0;
    endtask

    task automatic load(input logic [47:0] f1, input logic [47:0] f2);
        Fre1 = f1; Fre2 = f2; fre_load = 1'b1;
        step();
        fre_load = 1'b0;
    endtask

    initial begin
        int n;
        int exp_out[$];
        bit en_pat[9];
        sys_rst = 1'b1; en = 1'b0; phase_clr = 1'b0; fre_load = 1'b0;
        Fre1 = '0; Fre2 = '0; wave_sel = '0; amp1 = '0; amp2 = '0;

        vecs[0] = '{f1: F_Q, f2: 48'd0, ws: 2'b00, a1: 9'd256, a2: 9'd0, d: pack4(1, 255, -1, -256),  r1: 1'b1, r2: 1'b0};
        vecs[1] = '{f1: F_Q, f2: 48'd0, ws: 2'b01, a1: 9'd256, a2: 9'd0, d: pack4(0, 255, -1, -256),  r1: 1'b1, r2: 1'b0};
        vecs[2] = '{f1: F_Q, f2: F_Q,   ws: 2'b00, a1: 9'd256, a2: 9'd256, d: pack4(2, 511, -2, -511), r1: 1'b1, r2: 1'b1};
        vecs[3] = '{f1: F_Q, f2: 48'd0, ws: 2'b00, a1: 9'd128, a2: 9'd0, d: pack4(0, 127, -1, -128),  r1: 1'b1, r2: 1'b0};
        vecs[4] = '{f1: F_Q, f2: 48'd0, ws: 2'b00, a1: 9'd400, a2: 9'd0, d: pack4(1, 255, -1, -256),  r1: 1'b1, r2: 1'b0};
        vecs[5] = '{f1: 48'd0, f2: F_Q, ws: 2'b10, a1: 9'd0, a2: 9'd256, d: pack4(0, 255, -1, -256),  r1: 1'b0, r2: 1'b1};
        vecs[6] = '{f1: 48'd0, f2: 48'd0, ws: 2'b00, a1: 9'd256, a2: 9'd256, d: pack4(2, 2, 2, 2),    r1: 1'b0, r2: 1'b0};

        // Reset state
        step();
        do_reset();
        check("rst_valid", int'(data_valid), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_sync", int'({sync1, sync2}), 0);

        // Table-driven tone vectors
        foreach (vecs[v]) begin
            do_reset();
            wave_sel = vecs[v].ws; amp1 = vecs[v].a1; amp2 = vecs[v].a2;
            load(vecs[v].f1, vecs[v].f2);
            en = 1'b1;
            n = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (data_valid) begin
                    check($sformatf("vec%0d_data", v), int'(data_out), int'($signed(vecs[v].d[n % 4])));
                    check($sformatf("vec%0d_sync1", v), int'(sync1), int'(n == 0 || (vecs[v].r1 && n % 4 == 0)));
                    check($sformatf("vec%0d_sync2", v), int'(sync2), int'(n == 0 || (vecs[v].r2 && n % 4 == 0)));
                    n++;
                end
            end
            check($sformatf("vec%0d_count", v), n, 13);
            en = 1'b0;
        end

        // Handshake: en 1,0,1,1 must reappear on data_valid four cycles later
        do_reset();
        wave_sel = 2'b00; amp1 = 9'd256; amp2 = 9'd0;
        load(F_Q, 48'd0);
        en_pat = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
        exp_out = {1, 255, -1};
        for (int k = 0; k < 9; k++) begin
            en = en_pat[k];
            step();
            check("hs_valid", int'(data_valid), (k >= 3) ? int'(en_pat[k-3]) : 0);
            if (data_valid && exp_out.size() > 0) check("hs_data", int'(data_out), exp_out.pop_front());
        end

        // phase_clr mid-stream: gap, then a phase-0 sample carrying sync1
        en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("clr_gap", int'(data_valid), 0);
        step();
        check("clr_valid", int'(data_valid), 1);
        check("clr_data", int'(data_out), 1);
        check("clr_sync1", int'(sync1), 1);

        // fre_load together with en: that cycle still advances by the old word
        do_reset();
        load(F_Q, 48'd0);
        Fre1 = F_H; fre_load = 1'b1; en = 1'b1;
        step();
        fre_load = 1'b0;
        exp_out = {1, 255, -256, 255};
        for (int k = 0; k < 8; k++) begin
            step();
            if (data_valid && exp_out.size() > 0) check("load_data", int'(data_out), exp_out.pop_front());
        end
        check("load_count", exp_out.size(), 0);

        // Reset mid-stream: everything clears and nothing stale emerges
        for (int k = 0; k < 3; k++) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("mid_rst_valid", int'(data_valid), 0);
        check("mid_rst_data", int'(data_out), 0);
        check("mid_rst_sync", int'({sync1, sync2}), 0);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("mid_rst_stale", int'(data_valid), 0);
        end

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            sys_rst   = ($urandom_range(0, 99) < 2);
            en        = ($urandom_range(0, 9) < 7);
            phase_clr = ($urandom_range(0, 19) == 0);
            fre_load  = ($urandom_range(0, 9) == 0);
            Fre1      = {16'($urandom), $urandom};
            Fre2      = ($urandom_range(0, 3) == 0) ? 48'd0 : {16'($urandom), $urandom};
            wave_sel  = 2'($urandom_range(0, 3));
            amp1      = 9'($urandom_range(0, 511));
            amp2      = 9'($urandom_range(0, 511));
            step();
        end
        sys_rst = 1'b0; en = 1'b0; phase_clr = 1'b0; fre_load = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_tone_dds_gen.md
Name: dual_tone_dds_gen

Overview:
- Digital source for the signal-separation chain: synthesises the A+B mixed test signal that the one-order PLL / separation path receives.
- Two independent 48-bit DDS channels, each selectable sine or triangle, each with its own amplitude.
- Output is the scaled sum as a 10-bit signed sample stream (FPGA-internal loopback, or DAC feed for board-level tests).

Parameters:
- PHASE_W, 48, phase accumulator / frequency word width; tuning step = f_clk / 2^48.
- DATA_W, 10, output sample width, signed.
- AMP_W, 9, per-channel amplitude width; 256 = unity gain.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- en  in  1  sample enable; each high cycle launches one sample.
- phase_clr  in  1  zeroes both accumulators; has priority over en.
- fre_load  in  1  strobe; captures Fre1/Fre2 into shadow registers.
- Fre1  in  48  channel-1 frequency word.
- Fre2  in  48  channel-2 frequency word.
- wave_sel  in  2  bit0 = ch1 waveform, bit1 = ch2 waveform (0 = sine, 1 = triangle).
- amp1  in  9  channel-1 amplitude.
- amp2  in  9  channel-2 amplitude.
- data_out  out  10  signed mixed sample.
- data_valid  out  1  data_out is valid this cycle.
- sync1  out  1  ch1 period-start marker, aligned to data_valid.
- sync2  out  1  ch2 period-start marker, aligned to data_valid.

Behaviour:
- Reset: shadow words, accumulators, pipeline, data_out, data_valid, sync1 and sync2 all go to 0. data_valid is low from the cycle after sys_rst is sampled; an in-flight sample is discarded.
- Frequency load:
  - fre_load high in cycle t: shadow words load at the t edge. The first increment using the new word occurs in t+1.
  - Loading is phase-continuous; accumulators are not touched.
- Accumulator:
  - When en=1, the current accumulator value is the sample phase, and acc <= acc + shadow (mod 2^48).
  - When en=0, the accumulator holds.
  - phase_clr=1 sets acc to 0 and no sample is launched that cycle.
  - The wrap flag is the carry out of the add and travels with the sample.
- Phase decode, per channel: p = phase[47:38]; q = p[9:8]; i = p[7:0]; mirrored index m = (q odd) ? 255−i : i.
- Magnitude (9-bit unsigned):
  - Sine: ROM[m], where ROM[k] = round(511·sin(π/2·(k+0.5)/256)).
  - Triangle: {m, 1'b1}, range 1..511.
- Sign: positive for q ∈ {0,1}, negative for q ∈ {2,3}. Channel value s ∈ [−511, 511].
- Gain: ampc = min(amp, 256); scaled = (s·ampc) >>> 8, arithmetic shift with floor rounding.
- Mix: data_out = (scaled1 + scaled2) >>> 1. Full range is ±511, so no saturation is needed.
- Pipeline: 4 stages — accumulator, decode + ROM address, ROM read + sign, multiply, then sum.
  - en high at cycle t gives data_valid and data_out at cycle t+4.
  - Back-to-back en gives one sample per clock; gaps in en produce matching gaps in data_valid.
- Sync: sync1/sync2 pulse with the data_valid of the first sample whose phase follows an accumulator wrap of that channel. phase_clr counts as a wrap: the next sample launched carries sync.
- Simultaneous events:
  - fre_load with en in the same cycle: that cycle's increment uses the old word.
  - phase_clr with fre_load: both act.
  - sys_rst overrides everything.
- Shadow = 0: the channel outputs a constant; phase 0 → +ROM[0] or +1 scaled.

Decomposition:
- Package dds_pkg:
  - PHASE_W, DATA_W, AMP_W.
  - ROM depth 256 and magnitude width 9.
  - Waveform enum WAVE_SINE = 0, WAVE_TRI = 1.
  - Pipeline latency constant DDS_LAT = 4.
  - Unity-gain constant AMP_UNITY = 256.
- Sub-module dds_quarter_sine_rom: 256×9, registered output, one read port per channel (dual-port or two instances).

Test Plan:
- Sine, single tone:
  - Stimulus: reset, fre_load Fre1 = 2^46, Fre2 = 0, amp1 = 256, amp2 = 0, wave_sel = 0, en held high.
  - Required: after 4 cycles data_out repeats 1, 255, −1, −256.
  - sync1 is high on the first sample and on every 4th sample after it.
- Triangle, single tone:
  - Stimulus: same setup with wave_sel = 01.
  - Required: data_out repeats 0, 255, −1, −256.
- Mix:
  - Stimulus: Fre1 = Fre2 = 2^46, both sine, amp1 = amp2 = 256.
  - Required: data_out repeats 2, 511, −2, −511.
- Amplitude:
  - Stimulus: ch1 sine at 2^46, amp1 = 128.
  - Required: sequence 0, 127, −1, −128. amp1 = 400 gives the same result as amp1 = 256.
- Handshake and phase:
  - Stimulus: en toggled 1,0,1,1; phase_clr pulsed mid-stream; fre_load issued together with en.
  - Required: data_valid exactly mirrors en delayed 4 cycles. The sample after phase_clr has phase 0 and carries sync1. The new word takes effect one cycle after the load.
- Reset mid-stream: assert sys_rst for 1 cycle while samples are in flight → data_valid, data_out and sync go to 0 the next cycle, and no stale sample emerges afterwards.
